aes_round_ctrl: RTL and testbench
=================================

AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

Interface
REQ-001 SHALL have parameter NR, default 10, number of cipher rounds (AES-128); legal range 2..(2^RW)-1.
REQ-002 SHALL have parameter RW, default 4, width of round index.
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-005 SHALL have port start  input  1  request to begin one block encryption.
REQ-006 SHALL have port abort  input  1  synchronous cancel of the operation in progress.
REQ-007 SHALL have port ack  input  1  consumer has taken the result; releases done.
REQ-008 SHALL have port busy  output  1  high in INIT, ROUND, FINAL.
REQ-009 SHALL have port done  output  1  high in DONE; result valid.
REQ-010 SHALL have port round  output  RW  current round index, drives key schedule and rcon.
REQ-011 SHALL have port state_en  output  1  load enable for the state register.
REQ-012 SHALL have port key_en  output  1  load enable for the round-key register.
REQ-013 SHALL have port first  output  1  selects initial AddRoundKey path (plaintext in).
REQ-014 SHALL have port last  output  1  selects final round path (MixColumns bypassed).

Function
REQ-015 SHALL implement FSM states IDLE, INIT, ROUND, FINAL, DONE; all outputs registered-state decodes, no input-to-output combinational paths.
REQ-016 IDLE: start=1 -> INIT next cycle; start=0 -> stay; round held 0.
REQ-017 INIT: exactly 1 cycle; round=0, first=1, state_en=1, key_en=1; -> ROUND (round becomes 1).
REQ-018 ROUND: round increments by 1 per cycle, values 1..NR-1, state_en=1, key_en=1; on round=NR-1 -> FINAL with round=NR.
REQ-019 FINAL: exactly 1 cycle; round=NR, last=1, state_en=1, key_en=1; -> DONE.
REQ-020 DONE: done=1, state_en=0, key_en=0, round holds NR; ack=1 -> IDLE next cycle with round=0; ack=0 -> hold indefinitely.
REQ-021 Latency: start sampled in cycle T -> done first high in cycle T+NR+2; busy high for exactly NR+1 cycles.
REQ-022 start SHALL be ignored in every state other than IDLE, including DONE with ack=1 (no back-to-back; start must be presented in IDLE).
REQ-023 abort=1 in INIT, ROUND or FINAL SHALL force IDLE next cycle, round=0, done never asserted; abort in IDLE or DONE SHALL be ignored.
REQ-024 abort and start both high in IDLE: start wins (abort ignored in IDLE).
REQ-025 ack outside DONE SHALL be ignored.
REQ-026 round arithmetic SHALL be modulo 2^RW but SHALL never exceed NR; no wrap occurs for legal NR.
REQ-027 first and last SHALL never be high in the same cycle; state_en and key_en are equal in every cycle.
REQ-028 Unreachable state encodings SHALL return to IDLE next cycle.

Reset
REQ-029 reset=0 SHALL immediately (asynchronously) force IDLE, round=0, busy=done=state_en=key_en=first=last=0.
REQ-030 Reset assertion mid-operation SHALL discard the operation; after release, no done without a new start.
REQ-031 Deassertion of reset SHALL be the only synchronous reset-related event; first start accepted on the first rising edge with reset=1.

Verification
REQ-032 NR=10: start pulse at T -> busy T+1..T+11, first at T+1 only, round 1..9 at T+2..T+10, last with round=10 at T+11, done at T+12.
REQ-033 Hold ack=0 for 20 cycles in DONE -> done, round=10 stable, enables 0; ack=1 -> IDLE, round=0 next cycle.
REQ-034 abort at round=5 -> IDLE next cycle, round=0, done never seen; new start -> full normal sequence.
REQ-035 start held high continuously with ack=1 in DONE -> one idle cycle between done and next INIT; start pulses during busy have no effect.
REQ-036 reset=0 asynchronously between edges at round=7 -> all outputs 0 before next edge; after release, IDLE until start.
REQ-037 NR=2 build: start -> INIT, ROUND(round=1), FINAL(round=2), DONE; latency 4.

Source files
------------

// File: rtl/aes_round_ctrl.sv
// Round sequencer for an iterative AES datapath: steps the round index from the
// initial AddRoundKey through the final round and holds the result until it is acknowledged.
module aes_round_ctrl #(
  parameter int NR = 10,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic          ack,
  output logic          busy,
  output logic          done,
  output logic [RW-1:0] round,
  output logic          state_en,
  output logic          key_en,
  output logic          first,
  output logic          last,
  output logic [2:0]    o_dbg_state
);

  // Handshake: start is accepted only in IDLE, on the rising edge where it is high.
  // done stays high until ack is seen high on a rising edge, then the block
  // returns to IDLE for at least one cycle before it can accept another start.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_ROUND = 3'd2,
    S_FINAL = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [RW-1:0] LP_NR         = RW'(NR);
  localparam logic [RW-1:0] LP_LAST_ROUND = RW'(NR - 1);
  localparam logic [RW-1:0] LP_ONE        = RW'(1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [RW-1:0] r_round;
  logic [RW-1:0] w_round_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_round <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_round <= w_round_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_round_nxt = r_round;
    case (r_state)
      S_IDLE: begin
        w_round_nxt = '0;
        if (start) w_state_nxt = S_INIT;
      end
      S_INIT: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
          w_round_nxt = '0;
        end else begin
          w_state_nxt = S_ROUND;
          w_round_nxt = LP_ONE;
        end
      end
      S_ROUND: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
          w_round_nxt = '0;
        end else if (r_round == LP_LAST_ROUND) begin
          w_state_nxt = S_FINAL;
          w_round_nxt = LP_NR;
        end else begin
          w_round_nxt = r_round + LP_ONE;
        end
      end
      S_FINAL: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
          w_round_nxt = '0;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (ack) begin
          w_state_nxt = S_IDLE;
          w_round_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_round_nxt = '0;
      end
    endcase
  end

  // Every output is a decode of registered state, so reset clears them immediately.
  assign busy        = (r_state == S_INIT) || (r_state == S_ROUND) || (r_state == S_FINAL);
  assign done        = (r_state == S_DONE);
  assign state_en    = busy;
  assign key_en      = busy;
  assign first       = (r_state == S_INIT);
  assign last        = (r_state == S_FINAL);
  assign round       = r_round;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl: NR=10 instance for sequencing, abort, ack and
// async reset, plus an NR=2 instance for the minimum-length sequence.
module tb_aes_round_ctrl;

  localparam int W = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start, abort, ack;
  logic       busy, done, state_en, key_en, first, last;
  logic [3:0] round;
  logic [2:0] dbg_state;

  logic       start2, ack2;
  logic       busy2, done2, state_en2, key_en2, first2, last2;
  logic [3:0] round2;
  logic [2:0] dbg_state2;

  aes_round_ctrl #(.NR(10), .RW(4)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .ack(ack),
    .busy(busy), .done(done), .round(round), .state_en(state_en), .key_en(key_en),
    .first(first), .last(last), .o_dbg_state(dbg_state)
  );

  aes_round_ctrl #(.NR(2), .RW(4)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .abort(1'b0), .ack(ack2),
    .busy(busy2), .done(done2), .round(round2), .state_en(state_en2), .key_en(key_en2),
    .first(first2), .last(last2), .o_dbg_state(dbg_state2)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];

  // Expected word layout: {busy, done, state_en, key_en, first, last, round[3:0]}
  function automatic logic [W-1:0] mk(input logic b, input logic d, input logic f,
                                      input logic l, input logic [3:0] r);
    return {b, d, b, b, f, l, r};
  endfunction

  localparam logic [W-1:0] IDLE_W = '0;

  function automatic logic [W-1:0] obs_word(input int sel);
    if (sel == 0) return {busy, done, state_en, key_en, first, last, round};
    return {busy2, done2, state_en2, key_en2, first2, last2, round2};
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // tail: 0 = INIT and rounds up to upto_r, 1 = add FINAL, 2 = add FINAL and DONE
  task automatic push_run(input int nr, input int upto_r, input int tail);
    exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 4'd0));
    for (int r = 1; r <= upto_r && r <= nr - 1; r++)
      exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 4'(r)));
    if (tail >= 1) exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 4'(nr)));
    if (tail >= 2) exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 4'(nr)));
  endtask

  // First queued entry is the current cycle; noise keeps start and ack high throughout.
  task automatic drain(input string tag, input int sel, input bit noise);
    int i;
    i = 0;
    while (exp_q.size() > 0) begin
      if (noise) begin
        start = 1'b1;
        ack   = 1'b1;
      end
      if (i > 0) step();
      check(tag, obs_word(sel), exp_q.pop_front());
      i++;
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; abort = 1'b0; ack = 1'b0;
    start2 = 1'b0; ack2 = 1'b0;
    repeat (3) step();
    check("reset_idle", obs_word(0), IDLE_W);
    check("reset_idle2", obs_word(1), IDLE_W);
    check("reset_dbg", {7'd0, dbg_state}, '0);

    // Start presented together with reset release is taken on the first edge.
    reset = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    push_run(10, 9, 2);
    drain("nominal", 0, 1'b0);

    // DONE holds without ack; start/abort there are ignored.
    for (int i = 0; i < 20; i++) begin
      start = (i == 5); abort = (i == 5);
      step();
      check("done_hold", obs_word(0), mk(1'b0, 1'b1, 1'b0, 1'b0, 4'd10));
    end
    abort = 1'b0;
    ack = 1'b1; start = 1'b1;
    step();
    check("ack_release", obs_word(0), IDLE_W);
    step();
    check("b2b_init", obs_word(0), mk(1'b1, 1'b0, 1'b1, 1'b0, 4'd0));
    push_run(10, 9, 2);
    drain("b2b_run", 0, 1'b1);
    step();
    check("b2b_gap", obs_word(0), IDLE_W);
    step();
    check("b2b_next", obs_word(0), mk(1'b1, 1'b0, 1'b1, 1'b0, 4'd0));
    start = 1'b0; ack = 1'b0;
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_init", obs_word(0), IDLE_W);

    // start beats abort in IDLE; then abort at round 5.
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    push_run(10, 5, 0);
    drain("to_r5", 0, 1'b0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_r5", obs_word(0), IDLE_W);
    repeat (15) begin
      step();
      check("no_done", obs_word(0), IDLE_W);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    push_run(10, 9, 2);
    drain("after_abort", 0, 1'b0);
    ack = 1'b1;
    step();
    ack = 1'b0;
    check("ack_idle", obs_word(0), IDLE_W);

    start = 1'b1;
    step();
    start = 1'b0;
    push_run(10, 9, 1);
    drain("to_final", 0, 1'b0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_final", obs_word(0), IDLE_W);
    step();
    check("abort_final_hold", obs_word(0), IDLE_W);

    // Asynchronous reset between edges at round 7.
    start = 1'b1;
    step();
    start = 1'b0;
    push_run(10, 7, 0);
    drain("to_r7", 0, 1'b0);
    #3;
    reset = 1'b0;
    #1;
    check("async_rst", obs_word(0), IDLE_W);
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (3) begin
      step();
      check("post_rst_idle", obs_word(0), IDLE_W);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    push_run(10, 9, 2);
    drain("restart", 0, 1'b0);

    // Minimum-length build.
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    push_run(2, 1, 2);
    drain("nr2", 1, 1'b0);
    step();
    check("nr2_hold", obs_word(1), mk(1'b0, 1'b1, 1'b0, 1'b0, 4'd2));
    ack2 = 1'b1;
    step();
    ack2 = 1'b0;
    check("nr2_ack", obs_word(1), IDLE_W);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
